// File: rtl/action_update_pkg.sv
// Shared constants for the action_update block.
// Holds the action encoding and the key bit positions.
package action_update_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        JUMP  = 2'b10,
        SHOOT = 2'b11
    } action_e;

    localparam int KEY_RIGHT = 0;
    localparam int KEY_LEFT  = 1;
    localparam int KEY_JUMP  = 2;
    localparam int KEY_SHOOT = 3;

endpackage

// File: rtl/action_timer.sv
// Loadable down-counter holding an action active for a fixed length.
// busy stays high while the count is nonzero.
module action_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] length,
    output logic       busy,
    output logic [7:0] count
);

    assign busy = (count != 8'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 8'd0;
        end else if (load) begin
            count <= length;
        end else if (busy) begin
            count <= count - 8'd1;
        end
    end

endmodule

// File: rtl/action_update.sv
// Character action state: facing, step pulses, jump and shoot timing.
// All outputs are registered from the keys sampled at the same edge.
module action_update
    import action_update_pkg::*;
#(
    parameter int MOVE_DIV  = 4,
    parameter int JUMP_LEN  = 16,
    parameter int SHOOT_LEN = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] keys,
    output logic       direction,
    output logic [1:0] action,
    output logic [3:0] is_move
);

    logic [3:0] prev_keys;
    logic [7:0] step_cnt;
    logic       single;
    logic       prev_single;
    logic       switched;
    logic       step_wrap;
    logic       jump_fire;
    logic       shoot_fire;
    logic       jump_busy;
    logic       shoot_busy;
    logic [7:0] jump_cnt;
    logic [7:0] shoot_cnt;
    logic       jump_on;
    logic       shoot_on;
    action_e    action_next;

    assign single      = keys[KEY_RIGHT] ^ keys[KEY_LEFT];
    assign prev_single = prev_keys[KEY_RIGHT] ^ prev_keys[KEY_LEFT];
    // Reversing direction in one edge restarts the step cadence.
    assign switched    = single & prev_single &
                         (prev_keys[KEY_LEFT] != keys[KEY_LEFT]);
    assign step_wrap   = single & ~switched &
                         (step_cnt == 8'(MOVE_DIV - 1));

    assign jump_fire  = keys[KEY_JUMP] & ~prev_keys[KEY_JUMP] & ~jump_busy;
    assign shoot_fire = keys[KEY_SHOOT] & ~prev_keys[KEY_SHOOT] & ~shoot_busy;

    // Action follows the timer values this edge will produce.
    assign jump_on  = jump_fire | (jump_cnt > 8'd1);
    assign shoot_on = shoot_fire | (shoot_cnt > 8'd1);

    always_comb begin
        action_next = IDLE;
        if (jump_on) begin
            action_next = JUMP;
        end else if (shoot_on) begin
            action_next = SHOOT;
        end else if (single) begin
            action_next = RUN;
        end
    end

    action_timer u_jump_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (jump_fire),
        .length (8'(JUMP_LEN)),
        .busy   (jump_busy),
        .count  (jump_cnt)
    );

    action_timer u_shoot_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (shoot_fire),
        .length (8'(SHOOT_LEN)),
        .busy   (shoot_busy),
        .count  (shoot_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_keys <= 4'b0000;
            step_cnt  <= 8'd0;
            direction <= 1'b0;
            action    <= IDLE;
            is_move   <= 4'b0000;
        end else begin
            prev_keys <= keys;
            if (!single || switched || step_wrap) begin
                step_cnt <= 8'd0;
            end else begin
                step_cnt <= step_cnt + 8'd1;
            end
            if (single) begin
                direction <= keys[KEY_LEFT];
            end
            action  <= action_next;
            is_move <= {shoot_fire, jump_fire,
                        step_wrap & keys[KEY_LEFT],
                        step_wrap & keys[KEY_RIGHT]};
        end
    end

endmodule

// File: tb/tb_action_update.sv
// Directed self-checking bench for action_update.
// Expected values are hand-derived from the key sequences.
module tb_action_update;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] keys = 4'b0000;
    logic       direction;
    logic [1:0] action;
    logic [3:0] is_move;

    int n_cmp = 0;
    int n_bad = 0;
    int pulses;

    action_update #(
        .MOVE_DIV  (4),
        .JUMP_LEN  (16),
        .SHOOT_LEN (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .keys      (keys),
        .direction (direction),
        .action    (action),
        .is_move   (is_move)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic d,
                           input logic [1:0] a, input logic [3:0] m);
        chk({tag, ".dir"}, {7'd0, direction}, {7'd0, d});
        chk({tag, ".act"}, {6'd0, action}, {6'd0, a});
        chk({tag, ".mv"}, {4'd0, is_move}, {4'd0, m});
    endtask

    initial begin
        rst  = 1'b1;
        keys = 4'b0000;
        tick();
        tick();
        chk_all("reset", 1'b0, 2'b00, 4'b0000);

        rst    = 1'b0;
        keys   = 4'b0001;
        pulses = 0;
        for (int i = 1; i <= 250; i++) begin
            tick();
            chk_all("right", 1'b0, 2'b01,
                    (i % 4 == 0) ? 4'b0001 : 4'b0000);
            if (is_move[0]) pulses++;
        end
        chk("right.pulses", 8'(pulses), 8'd62);

        keys = 4'b0000;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk_all("release", 1'b0, 2'b00, 4'b0000);
        end

        keys = 4'b0010;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk_all("left", 1'b1, 2'b01,
                    (i == 4 || i == 8) ? 4'b0010 : 4'b0000);
        end
        keys = 4'b0011;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk_all("both", 1'b1, 2'b00, 4'b0000);
        end

        keys = 4'b0100;
        for (int i = 1; i <= 40; i++) begin
            tick();
            chk_all("jump", 1'b1, (i <= 16) ? 2'b10 : 2'b00,
                    (i == 1) ? 4'b0100 : 4'b0000);
        end
        keys = 4'b0000;
        tick();
        chk_all("jump.rel", 1'b1, 2'b00, 4'b0000);

        for (int i = 1; i <= 13; i++) begin
            keys = (i == 1 || i == 4 || i == 13) ? 4'b1000 : 4'b0000;
            tick();
            if (i <= 12) begin
                chk_all("shoot", 1'b1, (i <= 8) ? 2'b11 : 2'b00,
                        (i == 1) ? 4'b1000 : 4'b0000);
            end else begin
                chk_all("shoot.again", 1'b1, 2'b11, 4'b1000);
            end
        end
        keys = 4'b0000;
        tick();

        rst  = 1'b1;
        keys = 4'b0101;
        tick();
        tick();
        chk_all("rst2", 1'b0, 2'b00, 4'b0000);
        rst = 1'b0;
        for (int i = 1; i <= 24; i++) begin
            tick();
            chk_all("rjump", 1'b0, (i <= 16) ? 2'b10 : 2'b01,
                    {1'b0, i == 1, 1'b0, i % 4 == 0});
        end

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk_all("rjump2", 1'b0, 2'b10,
                    {1'b0, i == 1, 1'b0, i % 4 == 0});
        end
        rst = 1'b1;
        tick();
        chk_all("midrst", 1'b0, 2'b00, 4'b0000);
        rst  = 1'b0;
        keys = 4'b0000;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk_all("postrst", 1'b0, 2'b00, 4'b0000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/action_update.md
ACTION_UPDATE -- requirements
Module: action_update

Interface
REQ-001 Parameter MOVE_DIV, 4, clock cycles between horizontal step pulses; legal range 2..255.
REQ-002 Parameter JUMP_LEN, 16, cycles action stays JUMP after a jump start; legal range 1..255.
REQ-003 Parameter SHOOT_LEN, 8, cycles action stays SHOOT after a shot; legal range 1..255.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 keys  input  4  level key inputs: [0] right, [1] left, [2] jump, [3] shoot; 1 means pressed.
REQ-007 direction  output  1  facing: 0 right, 1 left; registered.
REQ-008 action  output  2  00 IDLE, 01 RUN, 10 JUMP, 11 SHOOT; registered.
REQ-009 is_move  output  4  one-cycle event pulses: [0] step right, [1] step left, [2] jump start, [3] shot fired; registered.

Function
REQ-010 keys SHALL be sampled each rising edge; all outputs SHALL reflect the sample one edge later, with no combinational input-to-output path.
REQ-011 Horizontal input is "single" when exactly one of keys[0], keys[1] is 1; both or neither SHALL count as no horizontal input.
REQ-012 direction SHALL become 0 on single right, 1 on single left, and hold its value otherwise.
REQ-013 An 8-bit step counter SHALL increment on every edge with single horizontal input and clear to 0 on every edge without it.
REQ-014 When the counter reaches MOVE_DIV-1 with single input held, it SHALL wrap to 0, and is_move[0] (right) or is_move[1] (left) SHALL pulse high for one cycle.
REQ-015 First step pulse SHALL appear after the MOVE_DIV-th consecutive sampled edge with the key held, then every MOVE_DIV edges.
REQ-016 A switch from single right to single left without an intervening edge of no input SHALL clear the counter.
REQ-017 A key rising edge SHALL be detected as key sampled 1 while its previous-sample register holds 0.
REQ-018 A jump rising edge with jump timer 0 SHALL pulse is_move[2] for one cycle and load the jump timer with JUMP_LEN; a jump edge while the timer is nonzero SHALL be ignored.
REQ-019 A shoot rising edge with shoot timer 0 SHALL pulse is_move[3] for one cycle and load the shoot timer with SHOOT_LEN; a shoot edge while the timer is nonzero SHALL be ignored.
REQ-020 Each nonzero timer SHALL decrement by 1 per edge; holding the key SHALL neither extend nor retrigger the timer.
REQ-021 action priority: JUMP while jump timer nonzero, else SHOOT while shoot timer nonzero, else RUN on single horizontal input, else IDLE.
REQ-022 Jump, shoot and step events on the same edge SHALL all pulse independently; is_move bits are not mutually exclusive.
REQ-023 Horizontal stepping and direction updates SHALL continue during JUMP and SHOOT.

Reset
REQ-024 While rst is 1 at an edge: direction=0, action=00, is_move=0000, step counter, both timers and previous-key registers SHALL become 0.
REQ-025 A key held through reset release SHALL be treated as a new rising edge on the first edge after reset.
REQ-026 Reset asserted mid-jump or mid-step SHALL abort the timers and counter with no further pulses.

Structure
REQ-027 Package action_update_pkg SHALL hold the action encoding constants (IDLE, RUN, JUMP, SHOOT) and the key index constants (KEY_RIGHT, KEY_LEFT, KEY_JUMP, KEY_SHOOT).
REQ-028 Sub-module action_timer (load, length, busy/count outputs) SHALL be instantiated twice, once for jump and once for shoot; step divider and output logic SHALL stay in action_update.

Verification
REQ-029 rst for 2 cycles, then keys=0001 held 250 cycles -> direction 0, action 01 from the first edge, is_move[0] pulses every 4 cycles (62 pulses), other bits 0.
REQ-030 Then keys=0000 -> action 00 one edge later; no further is_move pulses; direction stays 0.
REQ-031 keys=0010 for 10 cycles, then 0011 for 10 cycles -> direction 1, is_move[1] pulses at cycles 4 and 8; during 0011 action 00, no pulses, direction stays 1.
REQ-032 keys[2] 0->1 held 40 cycles -> single is_move[2] pulse, action 10 for exactly 16 cycles, then 00.
REQ-033 keys[3] pulsed at t and t+3 -> one is_move[3] pulse, action 11 for 8 cycles; a second press after expiry fires again.
REQ-034 keys=0101 (right + jump) from reset -> action 10 for 16 cycles then 01; step pulses continue throughout; rst mid-jump -> all outputs 0 next edge.
